// File: rtl/spi_reg_sequencer.sv
// Register-access front end for the spi master: turns one R/W request into
// 40-bit datagrams, times each frame and gap, and returns the driver's reply.
//
// state | meaning
// IDLE  | ready for a request; datagram and cs hold their last value
// FRAME | send enable high, timer counts FRAME_CYCLES
// GAP   | send enable low, timer counts GAP_CYCLES; reply captured on exit
// DONE  | one-cycle response strobe
module spi_reg_sequencer #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int CS_SIZE      = 1,
  parameter int FRAME_CYCLES = 512,
  parameter int GAP_CYCLES   = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic                       req_write_in,
  input  logic [ADDR_W-1:0]          req_addr_in,
  input  logic [DATA_W-1:0]          req_data_in,
  input  logic [CS_SIZE-1:0]         req_cs_in,
  output logic                       resp_valid_out,
  output logic [7:0]                 resp_status_out,
  output logic [DATA_W-1:0]          resp_data_out,
  output logic                       busy_out,
  output logic [ADDR_W+DATA_W:0]     spi_data_out,
  output logic                       spi_send_enable_out,
  output logic [CS_SIZE-1:0]         spi_cs_select_out,
  input  logic [ADDR_W+DATA_W:0]     spi_data_in
);

  localparam int DG_W  = 1 + ADDR_W + DATA_W;
  localparam int MAX_C = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_GAP, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic                write_q, write_d;
  logic                second_pass_q, second_pass_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                resp_valid_q, resp_valid_d;
  logic [7:0]          resp_status_q, resp_status_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [DG_W-1:0]     spi_data_q, spi_data_d;
  logic                spi_en_q, spi_en_d;
  logic [CS_SIZE-1:0]  spi_cs_q, spi_cs_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    write_d       = write_q;
    second_pass_d = second_pass_q;
    ready_d       = ready_q;
    busy_d        = busy_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    spi_data_d    = spi_data_q;
    spi_en_d      = spi_en_q;
    spi_cs_d      = spi_cs_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_in && ready_q) begin
          state_d       = ST_FRAME;
          timer_d       = '0;
          write_d       = req_write_in;
          second_pass_d = 1'b0;
          spi_data_d    = req_write_in ? {1'b1, req_addr_in, req_data_in}
                                       : {1'b0, req_addr_in, {DATA_W{1'b0}}};
          spi_cs_d      = req_cs_in;
          spi_en_d      = 1'b1;
          ready_d       = 1'b0;
          busy_d        = 1'b1;
        end
      end
      ST_FRAME: begin
        if (timer_q == FRAME_LAST) begin
          state_d  = ST_GAP;
          timer_d  = '0;
          spi_en_d = 1'b0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          // A read's data only arrives on the datagram after the one that asked for it.
          if (!write_q && !second_pass_q) begin
            state_d       = ST_FRAME;
            second_pass_d = 1'b1;
            spi_en_d      = 1'b1;
          end else begin
            state_d       = ST_DONE;
            resp_valid_d  = 1'b1;
            resp_status_d = spi_data_in[DATA_W +: 8];
            resp_data_d   = spi_data_in[DATA_W-1:0];
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        spi_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      write_q       <= 1'b0;
      second_pass_q <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_data_q   <= '0;
      spi_data_q    <= '0;
      spi_en_q      <= 1'b0;
      spi_cs_q      <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      write_q       <= write_d;
      second_pass_q <= second_pass_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
      spi_data_q    <= spi_data_d;
      spi_en_q      <= spi_en_d;
      spi_cs_q      <= spi_cs_d;
    end
  end

  assign req_ready_out       = ready_q;
  assign busy_out            = busy_q;
  assign resp_valid_out      = resp_valid_q;
  assign resp_status_out     = resp_status_q;
  assign resp_data_out       = resp_data_q;
  assign spi_data_out        = spi_data_q;
  assign spi_send_enable_out = spi_en_q;
  assign spi_cs_select_out   = spi_cs_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Self-checking bench for spi_reg_sequencer with short frame/gap timing and a
// reply-queue model standing in for the spi master's data_out.
module tb_spi_reg_sequencer;

  localparam int F = 8;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_cs = '0;
  logic        resp_valid;
  logic [7:0]  resp_status;
  logic [31:0] resp_data;
  logic        busy;
  logic [39:0] spi_dout;
  logic        spi_en;
  logic [1:0]  spi_cs;
  logic [39:0] spi_din = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] reply_q[$];
  logic [39:0] sb_q[$];
  logic        en_prev = 1'b0;
  int          frame_no = 0;

  spi_reg_sequencer #(
    .ADDR_W(7), .DATA_W(32), .CS_SIZE(2), .FRAME_CYCLES(F), .GAP_CYCLES(G)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_write_in(req_write), .req_addr_in(req_addr),
    .req_data_in(req_data), .req_cs_in(req_cs),
    .resp_valid_out(resp_valid), .resp_status_out(resp_status),
    .resp_data_out(resp_data), .busy_out(busy),
    .spi_data_out(spi_dout), .spi_send_enable_out(spi_en),
    .spi_cs_select_out(spi_cs), .spi_data_in(spi_din)
  );

  always #5 clk = ~clk;

  // spi master stand-in: each new frame presents the next queued reply
  always @(negedge clk) begin
    if (spi_en && !en_prev) begin
      frame_no = frame_no + 1;
      if (reply_q.size() > 0) spi_din = reply_q.pop_front();
      else                    spi_din = {8'hD0, 32'hDEAD0000 + 32'(frame_no)};
    end
    en_prev = spi_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge with the DUT in IDLE; returns at the falling edge
  // of the first IDLE cycle after DONE.
  task automatic run_txn(input logic wr, input logic [6:0] addr, input logic [31:0] data,
                         input logic [1:0] cs, input bit keep_valid,
                         input logic [39:0] reply1, input logic [39:0] reply2);
    logic [39:0] exp_dg, exp_resp, got;
    int total;
    bit en_exp;
    exp_dg   = wr ? {1'b1, addr, data} : {1'b0, addr, 32'h0};
    total    = wr ? F + G + 1 : 2 * F + 2 * G + 1;
    reply_q.push_back(reply1);
    if (!wr) reply_q.push_back(reply2);
    exp_resp = wr ? reply1 : reply2;
    sb_q.push_back(exp_resp);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = data; req_cs = cs;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_accept: got %b need 1", req_ready);
    end
    @(posedge clk);
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (keep_valid) begin
          req_write = ~wr; req_addr = addr ^ 7'h55; req_data = ~data; req_cs = ~cs;
        end else begin
          req_valid = 1'b0;
        end
      end
      en_exp = (i <= F) || (!wr && i > F + G && i <= 2 * F + G);
      n_checks += 6;
      if (spi_en !== en_exp) begin
        n_fail++; $display("FAIL enable cyc %0d: got %b need %b", i, spi_en, en_exp);
      end
      if (spi_dout !== exp_dg) begin
        n_fail++; $display("FAIL datagram cyc %0d: got %h need %h", i, spi_dout, exp_dg);
      end
      if (spi_cs !== cs) begin
        n_fail++; $display("FAIL cs cyc %0d: got %0d need %0d", i, spi_cs, cs);
      end
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL busy cyc %0d: got %b need 1", i, busy);
      end
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_busy cyc %0d: got %b need 0", i, req_ready);
      end
      if (resp_valid !== (i == total)) begin
        n_fail++; $display("FAIL resp_valid cyc %0d: got %b need %b", i, resp_valid, (i == total));
      end
      if (resp_valid === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL scoreboard: response with none expected, got %h", {resp_status, resp_data});
        end else begin
          got = sb_q.pop_front();
          if ({resp_status, resp_data} !== got) begin
            n_fail++; $display("FAIL response: got %h need %h", {resp_status, resp_data}, got);
          end
        end
      end
    end
    @(negedge clk);
    n_checks += 6;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_done: got %b need 1", req_ready);
    end
    if (busy !== 1'b0 || resp_valid !== 1'b0 || spi_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_flags: got busy=%b rv=%b en=%b need 0 0 0", busy, resp_valid, spi_en);
    end
    if (spi_cs !== cs) begin
      n_fail++; $display("FAIL cs_idle_hold: got %0d need %0d", spi_cs, cs);
    end
    if (spi_dout !== exp_dg) begin
      n_fail++; $display("FAIL datagram_idle_hold: got %h need %h", spi_dout, exp_dg);
    end
    if ({resp_status, resp_data} !== exp_resp) begin
      n_fail++; $display("FAIL resp_hold: got %h need %h", {resp_status, resp_data}, exp_resp);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries need 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, busy, spi_en} !== 4'b1000 || spi_dout !== 40'h0 ||
        spi_cs !== 2'd0 || resp_status !== 8'h0 || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b rv=%b busy=%b en=%b dout=%h cs=%0d st=%h d=%h need 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, busy, spi_en, spi_dout, spi_cs, resp_status, resp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    run_txn(1'b1, 7'h6C, 32'h00010203, 2'd0, 1'b0, 40'h3301020304, 40'h0);
    n_checks++;
    if (spi_dout !== 40'hEC00010203) begin
      n_fail++; $display("FAIL write_datagram: got %h need ec00010203", spi_dout);
    end
  endtask

  task automatic test_read();
    run_txn(1'b0, 7'h6F, 32'hFFFFFFFF, 2'd0, 1'b0, 40'h11AAAAAAAA, 40'h2212345678);
    n_checks++;
    if (resp_status !== 8'h22 || resp_data !== 32'h12345678) begin
      n_fail++; $display("FAIL read_result: got %h/%h need 22/12345678", resp_status, resp_data);
    end
  endtask

  task automatic test_hold_valid();
    run_txn(1'b1, 7'h12, 32'hCAFEF00D, 2'd1, 1'b1, 40'h44000000AA, 40'h0);
    run_txn(1'b1, 7'h34, 32'h0BADBEEF, 2'd3, 1'b0, 40'h55000000BB, 40'h0);
  endtask

  task automatic test_cs();
    run_txn(1'b0, 7'h01, 32'h0, 2'd2, 1'b0, 40'h6600000001, 40'h7700000002);
    repeat (3) @(negedge clk);
    n_checks++;
    if (spi_cs !== 2'd2) begin
      n_fail++; $display("FAIL cs_idle_long: got %0d need 2", spi_cs);
    end
  endtask

  task automatic test_reset_mid_read();
    int rv_seen;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h2A; req_data = '0; req_cs = 2'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (spi_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_precondition: got en=%b need 1", spi_en);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({req_ready, resp_valid, busy, spi_en} !== 4'b1000 || spi_dout !== 40'h0 || spi_cs !== 2'd0 ||
        resp_status !== 8'h0 || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset_values: got rdy=%b rv=%b busy=%b en=%b dout=%h cs=%0d need 1 0 0 0 0 0",
               req_ready, resp_valid, busy, spi_en, spi_dout, spi_cs);
    end
    rv_seen = 0;
    for (int i = 0; i < 2 * F + 2 * G + 4; i++) begin
      if (resp_valid === 1'b1 || spi_en === 1'b1) rv_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d active cycles need 0", rv_seen);
    end
    run_txn(1'b1, 7'h0F, 32'h89ABCDEF, 2'd1, 1'b0, 40'h88DEADBEEF, 40'h0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 7'h21, 32'h11111111, 2'd0, 1'b1, 40'h9911111111, 40'h0);
    run_txn(1'b1, 7'h22, 32'h22222222, 2'd1, 1'b1, 40'h9A22222222, 40'h0);
    run_txn(1'b1, 7'h23, 32'h33333333, 2'd2, 1'b0, 40'h9B33333333, 40'h0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_hold_valid();
    test_cs();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_sequencer.md
Name: spi_reg_sequencer

Overview:
- Upstream command stage for the `spi` master. It drives the master's `data_in`, `send_enable_in` and `cs_select` inputs and captures its `data_out`.
- Converts single register-access requests (R/W flag, 7-bit address, 32-bit data) into 40-bit driver datagrams.
- Times each frame by counting `clk_in` cycles, then returns the 8-bit status byte and 32-bit response word.
- A read costs two frames, because a driver read returns its data on the following datagram.

Parameters:
- ADDR_W, 7, register address width.
- DATA_W, 32, register data width. Datagram width = 1 + ADDR_W + DATA_W = 40.
- CS_SIZE, 1, chip-select index width, passed straight through to the `spi` master.
- FRAME_CYCLES, 512, `clk_in` cycles `spi_send_enable_out` stays high per frame. Must be ≥ 1 and must cover SIZE+2 `spi` internal clock periods.
- GAP_CYCLES, 64, `clk_in` cycles `spi_send_enable_out` stays low after each frame. Must be ≥ 1.
- CNT_W, $clog2(max(FRAME_CYCLES,GAP_CYCLES)+1), timer width. Derived; not to be overridden.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- req_valid_in  in  1  request valid.
- req_ready_out  out  1  request ready; high only in IDLE.
- req_write_in  in  1  1 = write, 0 = read.
- req_addr_in  in  ADDR_W  register address.
- req_data_in  in  DATA_W  write data; ignored on read.
- req_cs_in  in  CS_SIZE  target chip-select index.
- resp_valid_out  out  1  one-cycle response strobe.
- resp_status_out  out  8  captured datagram bits [39:32].
- resp_data_out  out  DATA_W  captured datagram bits [31:0].
- busy_out  out  1  high in every state except IDLE.
- spi_data_out  out  40  datagram to `spi` `data_in`.
- spi_send_enable_out  out  1  to `spi` `send_enable_in`.
- spi_cs_select_out  out  CS_SIZE  to `spi` `cs_select`.
- spi_data_in  in  40  from `spi` `data_out`.

Behaviour:
- All outputs are registered.
- Reset values: `req_ready_out`=1 (once in IDLE); `resp_valid_out`, `resp_status_out`, `resp_data_out`, `busy_out`, `spi_data_out`, `spi_send_enable_out`, `spi_cs_select_out` all 0. Timer = 0; `second_pass` = 0.
- Reset mid-operation: `spi_send_enable_out` is low on the first cycle after the reset edge, which aborts the `spi` frame. No `resp_valid_out` is produced for the aborted request.
- States: IDLE, FRAME, GAP, DONE.
- IDLE:
  - Accept when `req_valid_in` && `req_ready_out` at a rising edge.
  - Latch write flag, address, data and cs.
  - Write datagram: `spi_data_out` = {1'b1, addr, data}. Read datagram: {1'b0, addr, 32'h0}.
  - `spi_cs_select_out` = cs; `second_pass` = 0.
  - Go to FRAME with timer = 0.
  - `req_valid_in` while not in IDLE is ignored; there is no queuing.
- FRAME:
  - `spi_send_enable_out` = 1 for exactly FRAME_CYCLES consecutive cycles.
  - Timer counts 0..FRAME_CYCLES-1, then goes to GAP with timer = 0.
- GAP:
  - `spi_send_enable_out` = 0 for exactly GAP_CYCLES cycles.
  - On the edge leaving GAP, capture `spi_data_in` into an internal response register.
  - If read && !`second_pass`: set `second_pass` = 1 and return to FRAME with the same read datagram. The first-pass capture is discarded.
  - Otherwise go to DONE.
- DONE (one cycle):
  - `resp_valid_out` = 1, `resp_status_out` = capture[39:32], `resp_data_out` = capture[31:0].
  - Next edge: IDLE.
- Response outputs hold their values until the next DONE. Only `resp_valid_out` pulses.
- `spi_data_out` and `spi_cs_select_out` are stable from the cycle FRAME is entered until IDLE is re-entered. They keep their last value in IDLE.
- Latency, with accept at edge k:
  - Write: enable high in cycles k+1..k+F, low in k+F+1..k+F+G, `resp_valid_out` at k+F+G+1, `req_ready_out` again at k+F+G+2.
  - Read: enable high in k+1..k+F and k+F+G+1..k+2F+G; `resp_valid_out` at k+2F+G+G+1.
- A write also returns status and data (the driver's reply to the previous datagram).
- `busy_out` = (state ≠ IDLE).

Test Plan:
- F=8, G=4. Reset, then write addr 0x6C data 0x00010203 accepted at edge k → `spi_data_out` = 0xEC00010203; enable high cycles k+1..k+8, low k+9..k+12; `resp_valid_out` 1 cycle at k+13; `req_ready_out` high at k+14.
- Read addr 0x6F; `spi_data_in` model returns 0x11AAAAAAAA on frame 1 and 0x2212345678 on frame 2 → two 8-cycle enable pulses separated by a 4-cycle gap; `spi_data_out` = 0x6F00000000 throughout; `resp_status_out` = 0x22, `resp_data_out` = 0x12345678.
- `req_valid_in` held high with new values during a write → `req_ready_out` = 0 throughout; second request accepted only on the cycle after DONE; first datagram unchanged mid-frame.
- CS_SIZE=2, `req_cs_in` = 2 → `spi_cs_select_out` = 2 from FRAME entry through DONE; it keeps value 2 in IDLE.
- Assert `rst_in` at the 3rd FRAME cycle of a read → enable 0 next cycle; no `resp_valid_out`; all outputs at reset values; a fresh write then completes with nominal timing.
- Back-to-back writes with `req_valid_in` always high → exactly one idle cycle between responses; each enable pulse is exactly F cycles; no overlap.
